// File: rtl/action_insertion.sv
// action_insertion: header field writer for the match-action pipeline.
// Latches one HDR_W-bit header, overwrites FIELD_W-bit fields at bit offsets
// (counted from the header MSB) from a command stream, then presents the
// modified header downstream with valid/ready handshaking.
// Optional build macro ACTION_INSERT_MASK_EN adds a per-bit write mask (wr_mask).
module action_insertion #(
    parameter int HDR_W   = 2048,
    parameter int FIELD_W = 144,
    parameter int OFF_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hdr_in_valid,
    output logic               hdr_in_ready,
    input  logic [HDR_W-1:0]   hdr_in,
    input  logic               hdr_in_skip,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [OFF_W-1:0]   wr_offset,
    input  logic [FIELD_W-1:0] wr_data,
`ifdef ACTION_INSERT_MASK_EN
    input  logic [FIELD_W-1:0] wr_mask,
`endif
    input  logic               wr_last,
    output logic               hdr_out_valid,
    input  logic               hdr_out_ready,
    output logic [HDR_W-1:0]   hdr_out,
    output logic               err_oob,
    output logic               busy
);

    // Largest offset whose field still fits entirely inside the header.
    localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(HDR_W - FIELD_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t             state_q;
    logic [HDR_W-1:0]   hdr_q;
    logic               err_oob_q;

    logic               in_range;
    logic [FIELD_W-1:0] sel_mask;
    logic [HDR_W-1:0]   mask_wide;
    logic [HDR_W-1:0]   data_wide;
    logic [HDR_W-1:0]   hdr_wr_d;

`ifdef ACTION_INSERT_MASK_EN
    assign sel_mask = wr_mask;
`else
    assign sel_mask = '1;
`endif

    // Merge the command field into the header: place the field at the MSB end
    // and shift it right by the offset, then take only the selected bits.
    always_comb begin
        in_range  = (wr_offset <= MAX_OFF);
        mask_wide = {sel_mask, {(HDR_W-FIELD_W){1'b0}}} >> wr_offset;
        data_wide = {wr_data,  {(HDR_W-FIELD_W){1'b0}}} >> wr_offset;
        hdr_wr_d  = (hdr_q & ~mask_wide) | (data_wide & mask_wide);
    end

    // Control FSM together with the header register and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hdr_in_valid) begin
                        hdr_q   <= hdr_in;
                        state_q <= hdr_in_skip ? OUT : APPLY;
                    end
                end
                APPLY: begin
                    if (wr_valid) begin
                        // Out-of-range commands are consumed but leave the header alone.
                        if (in_range) begin
                            hdr_q <= hdr_wr_d;
                        end else begin
                            err_oob_q <= 1'b1;
                        end
                        if (wr_last) begin
                            state_q <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (hdr_out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only; no input reaches an output.
    assign hdr_in_ready  = (state_q == IDLE);
    assign wr_ready      = (state_q == APPLY);
    assign hdr_out_valid = (state_q == OUT);
    assign busy          = (state_q != IDLE);
    assign hdr_out       = hdr_q;
    assign err_oob       = err_oob_q;

endmodule

// File: tb/tb_action_insertion.sv
// Testbench for action_insertion: directed scenarios plus randomized headers
// and command streams checked against a bit-level reference model.
module tb_action_insertion;

    localparam int HDR_W   = 2048;
    localparam int FIELD_W = 144;
    localparam int OFF_W   = 12;

    logic               clk;
    logic               rst_n;
    logic               hdr_in_valid;
    logic               hdr_in_ready;
    logic [HDR_W-1:0]   hdr_in;
    logic               hdr_in_skip;
    logic               wr_valid;
    logic               wr_ready;
    logic [OFF_W-1:0]   wr_offset;
    logic [FIELD_W-1:0] wr_data;
`ifdef ACTION_INSERT_MASK_EN
    logic [FIELD_W-1:0] wr_mask;
`endif
    logic               wr_last;
    logic               hdr_out_valid;
    logic               hdr_out_ready;
    logic [HDR_W-1:0]   hdr_out;
    logic               err_oob;
    logic               busy;

    int n_cmp;
    int n_err;

    // Reference header: what the block should emit for the current transaction.
    logic [HDR_W-1:0] mdl;

    action_insertion #(.HDR_W(HDR_W), .FIELD_W(FIELD_W), .OFF_W(OFF_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hdr_in_valid  (hdr_in_valid),
        .hdr_in_ready  (hdr_in_ready),
        .hdr_in        (hdr_in),
        .hdr_in_skip   (hdr_in_skip),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_offset     (wr_offset),
        .wr_data       (wr_data),
`ifdef ACTION_INSERT_MASK_EN
        .wr_mask       (wr_mask),
`endif
        .wr_last       (wr_last),
        .hdr_out_valid (hdr_out_valid),
        .hdr_out_ready (hdr_out_ready),
        .hdr_out       (hdr_out),
        .err_oob       (err_oob),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Compare one value; wide mismatches report the 64-bit word holding the top differing bit.
    task automatic chk(input string tag, input logic [HDR_W-1:0] obs, input logic [HDR_W-1:0] exp);
        logic [HDR_W-1:0] x;
        int d;
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            x = obs ^ exp;
            d = 0;
            for (int i = 0; i < HDR_W; i++) if (x[i] !== 1'b0) d = i;
            $display("FAIL %s: got %h required %h (64-bit word %0d)",
                     tag, obs[(d/64)*64 +: 64], exp[(d/64)*64 +: 64], d/64);
        end
    endtask

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [HDR_W-1:0] h;
        for (int i = 0; i < HDR_W/32; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    function automatic logic [FIELD_W-1:0] rand_field();
        logic [FIELD_W-1:0] f;
        for (int i = 0; i < 5; i++) f[i*32 +: 32] = $urandom;
        f[143:128] = 16'($urandom);
        return f;
    endfunction

    // Model of one command: bit i of the field (from its MSB) lands at header bit HDR_W-1-off-i.
    task automatic model_write(input int off, input logic [FIELD_W-1:0] data,
                               input logic [FIELD_W-1:0] mask);
        if (off <= HDR_W - FIELD_W) begin
            for (int i = 0; i < FIELD_W; i++)
                if (mask[FIELD_W-1-i]) mdl[HDR_W-1-off-i] = data[FIELD_W-1-i];
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  HDR_W'(hdr_in_ready),  HDR_W'(1));
        chk({tag, "_wr_ready"},  HDR_W'(wr_ready),      HDR_W'(0));
        chk({tag, "_out_valid"}, HDR_W'(hdr_out_valid), HDR_W'(0));
        chk({tag, "_err_oob"},   HDR_W'(err_oob),       HDR_W'(0));
        chk({tag, "_busy"},      HDR_W'(busy),          HDR_W'(0));
        chk({tag, "_hdr"},       hdr_out,               '0);
    endtask

    // Present a header in IDLE; it is accepted at the next edge.
    task automatic send_hdr(input logic [HDR_W-1:0] h, input logic skip);
        chk("hdr_in_ready_idle", HDR_W'(hdr_in_ready), HDR_W'(1));
        hdr_in_valid = 1'b1;
        hdr_in       = h;
        hdr_in_skip  = skip;
        @(posedge clk); #1;
        hdr_in_valid = 1'b0;
        mdl = h;
        chk("hdr_in_ready_busy", HDR_W'(hdr_in_ready), HDR_W'(0));
        chk("busy_after_hdr",    HDR_W'(busy),         HDR_W'(1));
        if (skip) chk("skip_out_valid", HDR_W'(hdr_out_valid), HDR_W'(1));
        else      chk("apply_wr_ready", HDR_W'(wr_ready),      HDR_W'(1));
        $display("hdr  skip=%0d top=%h", skip, h[HDR_W-1 -: 32]);
    endtask

    // Issue one command (accepted at the next edge) with optional idle gap and header-side noise.
    task automatic send_cmd(input int off, input logic [FIELD_W-1:0] data,
                            input logic [FIELD_W-1:0] mask, input logic last, input int gap);
        logic oob;
        for (int g = 0; g < gap; g++) begin
            wr_valid = 1'b0;
            @(posedge clk); #1;
            chk("gap_wr_ready", HDR_W'(wr_ready), HDR_W'(1));
        end
        oob          = (off > HDR_W - FIELD_W);
        wr_valid     = 1'b1;
        wr_offset    = OFF_W'(off);
        wr_data      = data;
`ifdef ACTION_INSERT_MASK_EN
        wr_mask      = mask;
`endif
        wr_last      = last;
        hdr_in_valid = 1'($urandom_range(0, 1));
        hdr_in       = rand_hdr();
        @(posedge clk); #1;
        wr_valid     = 1'b0;
        hdr_in_valid = 1'b0;
`ifdef ACTION_INSERT_MASK_EN
        model_write(off, data, mask);
`else
        model_write(off, data, '1);
`endif
        chk("err_oob", HDR_W'(err_oob), HDR_W'(oob));
        chk("hdr_after_cmd", hdr_out, mdl);
        if (last) begin
            chk("last_out_valid", HDR_W'(hdr_out_valid), HDR_W'(1));
            chk("last_wr_ready",  HDR_W'(wr_ready),      HDR_W'(0));
        end else begin
            chk("mid_wr_ready",   HDR_W'(wr_ready),      HDR_W'(1));
            chk("mid_out_valid",  HDR_W'(hdr_out_valid), HDR_W'(0));
        end
        $display("cmd  off=%0d last=%0d oob=%0d data_lo=%h", off, last, oob, data[31:0]);
    endtask

    // Hold off downstream for 'stall' cycles (with ignored input noise), then take the header.
    task automatic recv(input int stall);
        chk("out_valid_entry", HDR_W'(hdr_out_valid), HDR_W'(1));
        chk("out_hdr_entry",   hdr_out, mdl);
        for (int s = 0; s < stall; s++) begin
            hdr_out_ready = 1'b0;
            hdr_in_valid  = 1'b1;
            hdr_in        = rand_hdr();
            hdr_in_skip   = 1'($urandom_range(0, 1));
            wr_valid      = 1'b1;
            wr_offset     = OFF_W'($urandom_range(0, HDR_W - FIELD_W));
            wr_data       = rand_field();
            @(posedge clk); #1;
            chk("stall_out_valid", HDR_W'(hdr_out_valid), HDR_W'(1));
            chk("stall_in_ready",  HDR_W'(hdr_in_ready),  HDR_W'(0));
            chk("stall_busy",      HDR_W'(busy),          HDR_W'(1));
            chk("stall_hdr",       hdr_out, mdl);
        end
        hdr_out_ready = 1'b1;
        @(posedge clk); #1;
        hdr_out_ready = 1'b0;
        hdr_in_valid  = 1'b0;
        wr_valid      = 1'b0;
        chk("post_out_valid", HDR_W'(hdr_out_valid), HDR_W'(0));
        chk("post_in_ready",  HDR_W'(hdr_in_ready),  HDR_W'(1));
        chk("post_busy",      HDR_W'(busy),          HDR_W'(0));
        $display("out  stall=%0d top=%h", stall, mdl[HDR_W-1 -: 32]);
    endtask

    function automatic int rand_off();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return HDR_W - FIELD_W;
            1:       return HDR_W - FIELD_W + 1;
            2:       return $urandom_range(HDR_W - FIELD_W + 1, (1 << OFF_W) - 1);
            3:       return 0;
            default: return $urandom_range(0, HDR_W - FIELD_W);
        endcase
    endfunction

    logic [HDR_W-1:0] pat;
    logic [FIELD_W-1:0] ones_f;

    initial begin
        n_cmp = 0;
        n_err = 0;
        mdl = '0;
        ones_f = '1;
        rst_n = 1'b0;
        hdr_in_valid = 1'b0;
        hdr_in = '0;
        hdr_in_skip = 1'b0;
        wr_valid = 1'b0;
        wr_offset = '0;
        wr_data = '0;
`ifdef ACTION_INSERT_MASK_EN
        wr_mask = '1;
`endif
        wr_last = 1'b0;
        hdr_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero header, one full-width write at offset 0.
        send_hdr('0, 1'b0);
        send_cmd(0, ones_f, '1, 1'b1, 0);
        chk("t1_fixed", hdr_out, {ones_f, {(HDR_W-FIELD_W){1'b0}}});
        recv(0);

        // Highest legal offset, then the first illegal one as the last command.
        send_hdr(rand_hdr(), 1'b0);
        send_cmd(HDR_W - FIELD_W, 144'h1234, '1, 1'b0, 0);
        chk("t2_low_field", HDR_W'(hdr_out[FIELD_W-1:0]), HDR_W'(144'h1234));
        send_cmd(HDR_W - FIELD_W + 1, ones_f, '1, 1'b1, 0);
        @(posedge clk); #1;
        chk("t2_err_oob_once", HDR_W'(err_oob), HDR_W'(0));
        recv(0);

        // Overlapping writes: the later one wins on shared bits.
        send_hdr('0, 1'b0);
        send_cmd(0, ones_f, '1, 1'b0, 0);
        send_cmd(8, '0, '1, 1'b1, 0);
        chk("t3_top_byte", HDR_W'(hdr_out[HDR_W-1 -: 8]), HDR_W'(8'hFF));
        chk("t3_cleared",  HDR_W'(hdr_out[HDR_W-9 -: FIELD_W]), '0);
        recv(0);

        // Skip with backpressure.
        for (int i = 0; i < HDR_W/8; i++) pat[i*8 +: 8] = 8'hA5;
        send_hdr(pat, 1'b1);
        recv(5);
        chk("t4_pattern", hdr_out, pat);

        // Reset in the middle of APPLY.
        send_hdr(rand_hdr(), 1'b0);
        send_cmd($urandom_range(0, HDR_W - FIELD_W), rand_field(), '1, 1'b0, 0);
        send_cmd($urandom_range(0, HDR_W - FIELD_W), rand_field(), '1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        chk_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midreset_release");
        pat = rand_hdr();
        send_hdr(pat, 1'b1);
        recv(1);
        chk("t5_new_hdr", hdr_out, pat);

`ifdef ACTION_INSERT_MASK_EN
        // Masked write touches only the selected field bits.
        send_hdr('0, 1'b0);
        send_cmd(0, ones_f, 144'hFF, 1'b1, 0);
        chk("t6_mask", hdr_out, HDR_W'(2048'hFF) << (HDR_W - FIELD_W));
        recv(0);
`endif

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int k;
            logic skip;
            skip = ($urandom_range(0, 3) == 0);
            send_hdr(rand_hdr(), skip);
            if (!skip) begin
                k = $urandom_range(1, 6);
                for (int c = 0; c < k; c++) begin
`ifdef ACTION_INSERT_MASK_EN
                    send_cmd(rand_off(), rand_field(), rand_field(), 1'(c == k - 1),
                             ($urandom_range(0, 3) == 0) ? 1 : 0);
`else
                    send_cmd(rand_off(), rand_field(), '1, 1'(c == k - 1),
                             ($urandom_range(0, 3) == 0) ? 1 : 0);
`endif
                end
            end
            recv($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
